// File: rtl/mem_write_scoreboard.sv
// Ordered expected-write checker: observed memory writes are compared in sequence
// against a loaded (address, data) table, and the result is reported as sticky flags.
module mem_write_scoreboard #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 8,
  parameter logic [WIDTH-1:0] IGN_ADDR = 'h60,
  parameter logic [WIDTH-1:0] IGN_MASK = '1,
  parameter int               TIMEOUT  = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       load_en,
  input  logic [WIDTH-1:0]           load_adr,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       start,
  input  logic                       MemWrite,
  input  logic [WIDTH-1:0]           DataAdr,
  input  logic [WIDTH-1:0]           WriteData,
  output logic                       load_full,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH+1)-1:0] match_cnt,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [WIDTH-1:0]           fail_adr,
  output logic [WIDTH-1:0]           fail_data,
  output logic [2:0]                 dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [TW-1:0]    timer, timer_n;
  logic [CW-1:0]    mcnt_n;
  logic [PW-1:0]    fidx_n;
  logic [WIDTH-1:0] fadr_n, fdata_n;
  logic             tbl_we;

  logic [WIDTH-1:0] exp_adr  [DEPTH];
  logic [WIDTH-1:0] exp_data [DEPTH];

  // Case equality so X/Z on the observed bus never counts as a match or an ignore.
  logic hit, ign, last;
  assign hit  = (DataAdr === exp_adr[ptr]) && (WriteData === exp_data[ptr]);
  assign ign  = ((DataAdr & IGN_MASK) === (IGN_ADDR & IGN_MASK));
  assign last = ((CW'(ptr) + 1'b1) == count);

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      exp_adr[count[PW-1:0]]  <= load_adr;
      exp_data[count[PW-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      ptr       <= '0;
      timer     <= '0;
      match_cnt <= '0;
      fail_idx  <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      ptr       <= ptr_n;
      timer     <= timer_n;
      match_cnt <= mcnt_n;
      fail_idx  <= fidx_n;
      fail_adr  <= fadr_n;
      fail_data <= fdata_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    ptr_n   = ptr;
    timer_n = timer;
    mcnt_n  = match_cnt;
    fidx_n  = fail_idx;
    fadr_n  = fail_adr;
    fdata_n = fail_data;
    tbl_we  = 1'b0;
    if (clear) begin
      state_n = S_IDLE;
      count_n = '0;
      ptr_n   = '0;
      timer_n = '0;
      mcnt_n  = '0;
      fidx_n  = '0;
      fadr_n  = '0;
      fdata_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_en && (count != CW'(DEPTH))) begin
            tbl_we  = 1'b1;
            count_n = count + 1'b1;
          end
          // start sees the entry loaded on the same edge
          if (start) begin
            if (count_n == '0) begin
              state_n = S_PASS;
            end else begin
              state_n = S_RUN;
              ptr_n   = '0;
              timer_n = '0;
              mcnt_n  = '0;
            end
          end
        end
        S_RUN: begin
          if (TIMEOUT != 0) timer_n = timer + 1'b1;
          if (MemWrite) begin
            if (hit) begin
              mcnt_n = match_cnt + 1'b1;
              if (last) state_n = S_PASS;
              else      ptr_n   = ptr + 1'b1;
            end else if (!ign) begin
              state_n = S_FAIL;
              fidx_n  = ptr;
              fadr_n  = DataAdr;
              fdata_n = WriteData;
            end
          end
          // a final match or a failure on the expiry edge takes precedence
          if ((TIMEOUT != 0) && (state_n == S_RUN) && (timer == TLAST))
            state_n = S_TOUT;
        end
        default: begin
        end
      endcase
    end
  end

  assign load_full = (count == CW'(DEPTH));
  assign busy      = (state == S_RUN);
  assign pass      = (state == S_PASS);
  assign fail      = (state == S_FAIL);
  assign timeout   = (state == S_TOUT);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Directed bench for mem_write_scoreboard: linear steps, immediate assertions at each check.
module tb_mem_write_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear, load_en, start, MemWrite;
  logic [31:0] load_adr, load_data, DataAdr, WriteData;
  logic        load_full, busy, pass, fail, timeout;
  logic [3:0]  match_cnt;
  logic [2:0]  fail_idx;
  logic [31:0] fail_adr, fail_data;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [63:0] ent;

  mem_write_scoreboard #(
    .WIDTH(32), .DEPTH(8), .IGN_ADDR(32'h60), .IGN_MASK(32'hFFFFFFFF), .TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .load_en(load_en),
    .load_adr(load_adr), .load_data(load_data), .start(start),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .load_full(load_full), .busy(busy), .pass(pass), .fail(fail),
    .timeout(timeout), .match_cnt(match_cnt), .fail_idx(fail_idx),
    .fail_adr(fail_adr), .fail_data(fail_data), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_adr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    step();
    MemWrite = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load_en = 1'b0; start = 1'b0; MemWrite = 1'b0;
    load_adr = '0; load_data = '0; DataAdr = '0; WriteData = '0;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {29'd0, pass, fail, timeout}, 0);
    chk("rst_mcnt", 32'(match_cnt), 0);
    chk("rst_full", 32'(load_full), 0);
    #3 reset = 1'b0;
    step();

    // single entry with ignored writes in front of it
    do_load(32'h64, 32'd14);
    do_start();
    chk("t1_busy", 32'(busy), 1);
    do_write(32'h60, 32'd5);
    do_write(32'h60, 32'd9);
    chk("t1_ign_pass", 32'(pass), 0);
    chk("t1_ign_busy", 32'(busy), 1);
    do_write(32'h64, 32'd14);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_fail", 32'(fail), 0);
    chk("t1_mcnt", 32'(match_cnt), 1);
    chk("t1_busy_drop", 32'(busy), 0);
    do_clear();

    // data mismatch with captures
    do_load(32'h64, 32'd14);
    do_start();
    do_write(32'h64, 32'd7);
    chk("t2_fail", 32'(fail), 1);
    chk("t2_idx", 32'(fail_idx), 0);
    chk("t2_adr", fail_adr, 32'h64);
    chk("t2_data", fail_data, 32'd7);
    do_write(32'h64, 32'd14);
    chk("t2_sticky_pass", 32'(pass), 0);
    chk("t2_sticky_fail", 32'(fail), 1);
    do_clear();
    chk("t2_clr_fail", 32'(fail), 0);
    chk("t2_clr_adr", fail_adr, 0);

    // ordering
    do_load(32'h10, 32'd1);
    do_load(32'h14, 32'd2);
    do_start();
    do_write(32'h14, 32'd2);
    chk("t3_fail", 32'(fail), 1);
    chk("t3_idx", 32'(fail_idx), 0);
    do_clear();
    do_load(32'h10, 32'd1);
    do_load(32'h14, 32'd2);
    do_start();
    do_write(32'h10, 32'd1);
    chk("t3_mid_mcnt", 32'(match_cnt), 1);
    chk("t3_mid_busy", 32'(busy), 1);
    do_write(32'h14, 32'd2);
    chk("t3_pass", 32'(pass), 1);
    chk("t3_mcnt", 32'(match_cnt), 2);
    do_clear();

    // timeout after exactly 20 RUN edges
    do_load(32'h20, 32'd3);
    do_start();
    repeat (19) step();
    chk("t4_pre_tout", 32'(timeout), 0);
    chk("t4_pre_busy", 32'(busy), 1);
    step();
    chk("t4_tout", 32'(timeout), 1);
    chk("t4_tout_busy", 32'(busy), 0);
    chk("t4_tout_pass", 32'(pass), 0);
    do_clear();
    do_load(32'h20, 32'd3);
    do_start();
    repeat (19) step();
    do_write(32'h20, 32'd3);
    chk("t4_last_pass", 32'(pass), 1);
    chk("t4_last_tout", 32'(timeout), 0);
    do_clear();
    // mismatch on the expiry edge reports FAIL, not timeout
    do_load(32'h20, 32'd3);
    do_start();
    repeat (19) step();
    do_write(32'h24, 32'd3);
    chk("t4_last_fail", 32'(fail), 1);
    chk("t4_last_fail_tout", 32'(timeout), 0);
    do_clear();

    // empty table: start passes at once
    do_start();
    chk("t5_empty_pass", 32'(pass), 1);
    chk("t5_empty_busy", 32'(busy), 0);
    do_clear();

    // full table, ninth load discarded
    for (int i = 0; i < 9; i++) begin
      ent = {32'h100 + 32'(4 * i), 32'(3 * i + 1)};
      exp_q.push_back(ent);
      do_load(ent[63:32], ent[31:0]);
      if (i == 6) chk("t5_full7", 32'(load_full), 0);
      if (i == 7) chk("t5_full8", 32'(load_full), 1);
    end
    chk("t5_full9", 32'(load_full), 1);
    do_start();
    for (int i = 0; i < 8; i++) begin
      ent = exp_q.pop_front();
      do_write(ent[63:32], ent[31:0]);
      if (i == 6) chk("t5_mcnt7", 32'(match_cnt), 7);
    end
    ent = exp_q.pop_front();
    chk("t5_pass", 32'(pass), 1);
    chk("t5_mcnt8", 32'(match_cnt), 8);
    chk("t5_q_left", 32'(exp_q.size()), 0);
    do_clear();

    // async reset mid-RUN
    do_load(32'h30, 32'd5);
    do_load(32'h34, 32'd6);
    do_start();
    do_write(32'h30, 32'd5);
    chk("t6_pre_mcnt", 32'(match_cnt), 1);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_mcnt", 32'(match_cnt), 0);
    chk("t6_rst_flags", {29'd0, pass, fail, timeout}, 0);
    #1 reset = 1'b0;
    step();
    do_load(32'h30, 32'd5);
    do_start();
    do_write('x, 32'd5);
    chk("t6_x_fail", 32'(fail), 1);
    chk("t6_x_idx", 32'(fail_idx), 0);
    do_write(32'h30, 32'd5);
    chk("t6_x_pass", 32'(pass), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_write_scoreboard.md
Name: mem_write_scoreboard

Overview:
- Parametrised, self-contained checker for processor memory-write traffic. Used in the processor testbench and in FPGA self-test wrappers next to the top-level core.
- Holds an ordered table of up to DEPTH expected (address, data) writes and compares each observed write against the next table entry.
- Skips writes to a maskable "ignore" address.
- Reports pass, fail (with the offending index, address and data) or timeout as sticky flags, replacing ad-hoc single-write checks.

Parameters:
WIDTH, 32, address/data width
DEPTH, 8, expected-write table entries (>=2)
IGN_ADDR, 32'h60, address whose writes are skipped
IGN_MASK, 32'hFFFFFFFF, bits of the address compared against IGN_ADDR; 0 means every non-matching write is ignored
TIMEOUT, 1000, RUN cycles allowed before timeout; 0 disables the timeout

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous: return to IDLE and empty the table
load_en  in  1  push one expected entry (IDLE only)
load_adr  in  WIDTH  expected address
load_data  in  WIDTH  expected data
start  in  1  arm the checker (IDLE only)
MemWrite  in  1  observed write strobe
DataAdr  in  WIDTH  observed write address
WriteData  in  WIDTH  observed write data
load_full  out  1  table holds DEPTH entries
busy  out  1  state is RUN
pass  out  1  sticky: all entries matched
fail  out  1  sticky: mismatching write seen
timeout  out  1  sticky: RUN exceeded TIMEOUT
match_cnt  out  $clog2(DEPTH+1)  entries matched so far
fail_idx  out  $clog2(DEPTH)  table index at failure
fail_adr  out  WIDTH  captured failing address
fail_data  out  WIDTH  captured failing data

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, ptr=0, timer=0, all outputs 0. Table contents are don't-care. Reset mid-RUN aborts with no flag.
- States: IDLE, RUN, PASS, FAIL, TOUT. PASS, FAIL and TOUT are terminal; only clear or reset leaves them.
- clear (any state): next edge goes to IDLE, count/ptr/timer/flags/captures are zeroed. clear has priority over load_en, start and MemWrite.
- IDLE:
  - load_en with count<DEPTH writes the entry at index count, then count++.
  - load_en with count==DEPTH is discarded silently.
  - load_full = (count==DEPTH).
  - start with count==0 goes to PASS. start with count>0 goes to RUN with ptr=0, timer=0.
  - load_en and start in the same cycle: the entry is stored and the start uses the updated count.
- load_en and start outside IDLE are ignored. MemWrite outside RUN is ignored.
- RUN, per edge with MemWrite=1, rules in priority order:
  1. DataAdr===exp_adr[ptr] and WriteData===exp_data[ptr] is a match: ptr++, match_cnt++. If ptr was count-1, go to PASS.
  2. Otherwise, if (DataAdr & IGN_MASK)==(IGN_ADDR & IGN_MASK), the write is ignored with no state change.
  3. Otherwise go to FAIL and capture fail_idx=ptr, fail_adr=DataAdr, fail_data=WriteData.
- Comparisons use case equality, so X/Z on observed signals mismatches in simulation.
- Timer:
  - Increments every RUN edge.
  - If TIMEOUT!=0 and timer==TIMEOUT-1 and this edge produced no final match and no FAIL, go to TOUT.
  - A final match on the same edge wins (PASS). A mismatch on the same edge wins (FAIL).
- Latency: pass/fail/timeout rise in the cycle after the deciding edge. busy drops in the same cycle.
- Exactly one of pass/fail/timeout is ever 1. Captures hold until clear/reset.
- Widths: match_cnt saturates naturally at count (<=DEPTH). The timer is $clog2(TIMEOUT+1) bits wide and never wraps, because it stops at TIMEOUT-1.

Test Plan:
1. Load (0x64,14); start; writes 0x60/5, 0x60/9, then 0x64/14 -> pass=1 one cycle after the 0x64 edge, fail=0, match_cnt=1, busy=0.
2. Load (0x64,14); start; write 0x64/7 -> fail=1, fail_idx=0, fail_adr=0x64, fail_data=7, pass stays 0 after a later 0x64/14.
3. Ordering: load (0x10,1),(0x14,2); write 0x14/2 first -> fail=1, fail_idx=0. After clear, reload and write in order -> pass=1, match_cnt=2.
4. Timeout with TIMEOUT=20, one entry, no writes -> timeout=1 exactly 20 cycles after RUN entry. Rerun with the matching write on the 20th RUN edge -> pass=1, timeout=0.
5. DEPTH=8: load 9 entries -> load_full=1 after the 8th, 9th entry discarded. Eight in-order matches -> pass=1, match_cnt=8.
6. Assert reset asynchronously between edges mid-RUN -> busy/match_cnt/flags go to 0 immediately. With DataAdr=X and MemWrite=1 in RUN -> fail=1.
